// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-port bundle for mem_port_arbiter.
// slave = arbiter view, master = CPU/AXI side view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              flush;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ready;
    logic [31:0]       i_rdata;
    logic              d_req;
    logic              d_write;
    logic [1:0]        d_size;
    logic [3:0]        d_sel;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_ready;
    logic [31:0]       d_rdata;
    logic              mem_access;
    logic              mem_write;
    logic [1:0]        mem_size;
    logic [3:0]        mem_sel;
    logic [ADDR_W-1:0] mem_a;
    logic [31:0]       mem_st_data;
    logic              mem_ready;
    logic [31:0]       mem_data;

    modport slave (
        input  flush, i_req, i_addr, d_req, d_write, d_size, d_sel, d_addr, d_wdata,
        input  mem_ready, mem_data,
        output i_ready, i_rdata, d_ready, d_rdata,
        output mem_access, mem_write, mem_size, mem_sel, mem_a, mem_st_data
    );

    modport master (
        output flush, i_req, i_addr, d_req, d_write, d_size, d_sel, d_addr, d_wdata,
        output mem_ready, mem_data,
        input  i_ready, i_rdata, d_ready, d_rdata,
        input  mem_access, mem_write, mem_size, mem_sel, mem_a, mem_st_data
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requesters onto the single mem_* port, data first.
// Optional fetch starvation protection: define MEM_ARB_FAIRNESS_EN.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32
) (
    input logic            aclk,
    input logic            aresetn,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    if (STARVE_LIMIT < 1) begin : g_limit_chk
        $error("STARVE_LIMIT must be at least 1");
    end

    state_t            r_state, w_next;
    logic              r_drop;
    logic              r_mem_access;
    logic              r_mem_write;
    logic [1:0]        r_mem_size;
    logic [3:0]        r_mem_sel;
    logic [ADDR_W-1:0] r_mem_a;
    logic [31:0]       r_mem_st_data;
    logic              w_idle_ok;
    logic              w_force_i;
    logic              w_grant_d;
    logic              w_grant_i;

`ifdef MEM_ARB_FAIRNESS_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
    logic [CNT_W-1:0] r_starve_cnt;

    assign w_force_i = (r_starve_cnt == LIMIT) & bus.i_req & bus.d_req;

    // Counts data grants that overtook a waiting fetch; saturates at LIMIT.
    always_ff @(posedge aclk) begin
        if (!aresetn)
            r_starve_cnt <= '0;
        else if (r_state == IDLE) begin
            if (!bus.i_req || w_grant_i)
                r_starve_cnt <= '0;
            else if (w_grant_d && r_starve_cnt != LIMIT)
                r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end
`else
    assign w_force_i = 1'b0;
`endif

    assign w_idle_ok = (r_state == IDLE) & ~bus.flush;
    assign w_grant_d = w_idle_ok & bus.d_req & ~w_force_i;
    assign w_grant_i = w_idle_ok & bus.i_req & (~bus.d_req | w_force_i);

    always_ff @(posedge aclk) begin
        if (!aresetn) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:         if (w_grant_d)     w_next = GNT_D;
                          else if (w_grant_i) w_next = GNT_I;
            GNT_I, GNT_D: if (bus.mem_ready) w_next = IDLE;
            default:      w_next = IDLE;
        endcase
    end

    // Ready pulses are combinational so the owner sees completion in the mem_ready cycle.
    always_comb begin
        bus.i_ready = bus.mem_ready & (r_state == GNT_I) & ~r_drop & ~bus.flush;
        bus.d_ready = bus.mem_ready & (r_state == GNT_D) & ~r_drop & ~bus.flush;
        bus.i_rdata = bus.mem_data;
        bus.d_rdata = bus.mem_data;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_drop        <= 1'b0;
            r_mem_access  <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_size    <= 2'b00;
            r_mem_sel     <= 4'h0;
            r_mem_a       <= '0;
            r_mem_st_data <= 32'h0;
        end else if (w_grant_d) begin
            r_mem_access  <= 1'b1;
            r_mem_write   <= bus.d_write;
            r_mem_size    <= bus.d_size;
            r_mem_sel     <= bus.d_sel;
            r_mem_a       <= bus.d_addr;
            r_mem_st_data <= bus.d_wdata;
        end else if (w_grant_i) begin
            r_mem_access  <= 1'b1;
            r_mem_write   <= 1'b0;
            r_mem_size    <= 2'b10;
            r_mem_sel     <= 4'hF;
            r_mem_a       <= bus.i_addr;
            r_mem_st_data <= 32'h0;
        end else if (r_state != IDLE) begin
            // A flushed transaction still runs to mem_ready so the AXI channel closes.
            if (bus.mem_ready) begin
                r_mem_access <= 1'b0;
                r_drop       <= 1'b0;
            end else if (bus.flush) begin
                r_drop <= 1'b1;
            end
        end
    end

    assign bus.mem_access  = r_mem_access;
    assign bus.mem_write   = r_mem_write;
    assign bus.mem_size    = r_mem_size;
    assign bus.mem_sel     = r_mem_sel;
    assign bus.mem_a       = r_mem_a;
    assign bus.mem_st_data = r_mem_st_data;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int LIMIT = 4;

    logic aclk = 1'b0;
    logic aresetn;
    int   n_checks = 0;
    int   n_err = 0;

    mem_port_arbiter_if #(.ADDR_W(32)) bus ();

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(32)) dut (
        .aclk(aclk), .aresetn(aresetn), .bus(bus.slave)
    );

    always #5 aclk = ~aclk;

    // Model: owner 0 = none, 1 = fetch, 2 = data; plus the latched request.
    int          m_own, m_cnt;
    bit          m_drop, m_acc, m_wr;
    logic [1:0]  m_size;
    logic [3:0]  m_sel;
    logic [31:0] m_a, m_wd;
    int          i_pulses, d_pulses, f_grants, dt_grants;
    bit          prev_acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_own = 0; m_cnt = 0; m_drop = 0; m_acc = 0; m_wr = 0;
        m_size = 0; m_sel = 0; m_a = 0; m_wd = 0;
    endtask

    task automatic model_update();
        bit fair_i;
        if (!aresetn) begin
            model_reset();
            return;
        end
        if (m_own == 0) begin
`ifdef MEM_ARB_FAIRNESS_EN
            fair_i = bus.i_req && bus.d_req && (m_cnt == LIMIT);
`else
            fair_i = 0;
`endif
            if (!bus.flush && bus.d_req && !fair_i) begin
                m_own = 2; m_acc = 1; m_wr = bus.d_write; m_size = bus.d_size;
                m_sel = bus.d_sel; m_a = bus.d_addr; m_wd = bus.d_wdata;
                m_cnt = bus.i_req ? ((m_cnt < LIMIT) ? m_cnt + 1 : LIMIT) : 0;
            end else if (!bus.flush && bus.i_req) begin
                m_own = 1; m_acc = 1; m_wr = 0; m_size = 2'b10;
                m_sel = 4'hF; m_a = bus.i_addr; m_wd = 0;
                m_cnt = 0;
            end else if (!bus.i_req) begin
                m_cnt = 0;
            end
        end else if (bus.mem_ready) begin
            m_own = 0; m_acc = 0; m_drop = 0;
        end else if (bus.flush) begin
            m_drop = 1;
        end
    endtask

    // One clock: compare at the falling edge, advance the model, return 1 after the rising edge.
    task automatic step();
        bit ei, ed;
        @(negedge aclk);
        ei = bus.mem_ready && m_own == 1 && !m_drop && !bus.flush;
        ed = bus.mem_ready && m_own == 2 && !m_drop && !bus.flush;
        chk("mem_access", bus.mem_access, m_acc);
        chk("mem_write", bus.mem_write, m_wr);
        chk("mem_size", bus.mem_size, m_size);
        chk("mem_sel", bus.mem_sel, m_sel);
        chk("mem_a", bus.mem_a, m_a);
        chk("mem_st_data", bus.mem_st_data, m_wd);
        chk("i_ready", bus.i_ready, ei);
        chk("d_ready", bus.d_ready, ed);
        if (ei) chk("i_rdata", bus.i_rdata, bus.mem_data);
        if (ed) chk("d_rdata", bus.d_rdata, bus.mem_data);
        if (bus.i_ready) i_pulses++;
        if (bus.d_ready) d_pulses++;
        if (bus.mem_access && !prev_acc) begin
            if (bus.mem_write) dt_grants++; else f_grants++;
        end
        prev_acc = bus.mem_access;
        model_update();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.flush = 0; bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_write = 0;
        bus.d_size = 0; bus.d_sel = 0; bus.d_addr = 0; bus.d_wdata = 0;
        bus.mem_ready = 0; bus.mem_data = 0;
    endtask

    task automatic do_reset();
        aresetn = 0;
        step(); step();
        aresetn = 1;
    endtask

    initial begin
        idle_inputs();
        aresetn = 0;
        model_reset();
        prev_acc = 0;
        i_pulses = 0; d_pulses = 0; f_grants = 0; dt_grants = 0;
        @(posedge aclk); #1;
        do_reset();

        // Fetch only
        bus.i_req = 1; bus.i_addr = 32'hBFC00000;
        step();
        chk("fo_access", bus.mem_access, 1);
        chk("fo_addr", bus.mem_a, 32'hBFC00000);
        chk("fo_sel", bus.mem_sel, 4'hF);
        chk("fo_size", bus.mem_size, 2);
        step(); step();
        bus.mem_ready = 1; bus.mem_data = 32'h3C080001;
        #1;
        chk("fo_iready", bus.i_ready, 1);
        chk("fo_rdata", bus.i_rdata, 32'h3C080001);
        chk("fo_dready", bus.d_ready, 0);
        step();
        bus.i_req = 0; bus.mem_ready = 0;
        step();
        chk("fo_done", bus.mem_access, 0);

        // Simultaneous requests, then stability of a held data grant
        bus.i_req = 1; bus.i_addr = 32'hBFC00010;
        bus.d_req = 1; bus.d_write = 1; bus.d_addr = 32'h1FAF0000;
        bus.d_sel = 4'h3; bus.d_size = 2'b01; bus.d_wdata = 32'h1234;
        step();
        chk("sim_write", bus.mem_write, 1);
        chk("sim_sel", bus.mem_sel, 4'h3);
        bus.d_addr = 32'h0;
        step();
        chk("stab_addr", bus.mem_a, 32'h1FAF0000);
        bus.mem_ready = 1;
        step();
        bus.d_req = 0; bus.mem_ready = 0;
        chk("sim_gap", bus.mem_access, 0);
        step();
        chk("sim_fetch", bus.mem_a, 32'hBFC00010);
        chk("sim_fwrite", bus.mem_write, 0);
        bus.mem_ready = 1;
        step();
        bus.i_req = 0; bus.mem_ready = 0;
        step();

        // Flush in flight
        i_pulses = 0;
        bus.i_req = 1; bus.i_addr = 32'hBFC00100;
        step();
        bus.flush = 1;
        step();
        bus.flush = 0; bus.i_req = 0;
        step();
        chk("fl_held", bus.mem_access, 1);
        bus.mem_ready = 1;
        step();
        bus.mem_ready = 0;
        chk("fl_no_pulse", i_pulses, 0);
        bus.i_req = 1; bus.i_addr = 32'hBFC00380;
        step();
        chk("fl_regrant", bus.mem_a, 32'hBFC00380);
        bus.mem_ready = 1;
        step();
        bus.i_req = 0; bus.mem_ready = 0;
        chk("fl_next_pulse", i_pulses, 1);

        // Reset mid data transaction, late mem_ready
        d_pulses = 0;
        bus.d_req = 1; bus.d_write = 0; bus.d_addr = 32'h00001000; bus.d_sel = 4'hF;
        step();
        bus.d_req = 0;
        aresetn = 0;
        step();
        aresetn = 1;
        chk("rst_access", bus.mem_access, 0);
        chk("rst_addr", bus.mem_a, 0);
        bus.mem_ready = 1;
        step();
        bus.mem_ready = 0;
        chk("rst_no_pulse", d_pulses, 0);

        // Both requesters held continuously
        do_reset();
        f_grants = 0; dt_grants = 0;
        bus.i_req = 1; bus.i_addr = 32'hBFC00200;
        bus.d_req = 1; bus.d_write = 1; bus.d_addr = 32'h1FAF0040;
        bus.mem_ready = 1;
        for (int k = 0; k < 40; k++) step();
`ifdef MEM_ARB_FAIRNESS_EN
        chk("fair_fetch", f_grants, 4);
        chk("fair_data", dt_grants, 16);
`else
        chk("strict_fetch", f_grants, 0);
        chk("strict_data", dt_grants, 20);
`endif
        idle_inputs();
        do_reset();

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            aresetn       = ($urandom_range(0, 199) != 0);
            bus.flush     = ($urandom_range(0, 15) == 0);
            bus.i_req     = ($urandom_range(0, 2) != 0);
            bus.d_req     = ($urandom_range(0, 1) != 0);
            bus.i_addr    = $urandom;
            bus.d_write   = $urandom_range(0, 1);
            bus.d_size    = 2'($urandom_range(0, 3));
            bus.d_sel     = 4'($urandom_range(0, 15));
            bus.d_addr    = $urandom;
            bus.d_wdata   = $urandom;
            bus.mem_ready = ($urandom_range(0, 2) == 0);
            bus.mem_data  = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
